// File: rtl/signed_divider_if.sv
// Handshake and data bundle for the sequential signed divider.
// The requester drives start and the operands; the divider returns
// status, the result pair and the exception flags.
interface signed_divider_if #(
    parameter int WORD_LENGTH = 16
);
    logic                          start;
    logic signed [WORD_LENGTH-1:0] dividend;
    logic signed [WORD_LENGTH-1:0] divisor;
    logic                          busy;
    logic                          done;
    logic signed [WORD_LENGTH-1:0] quotient;
    logic signed [WORD_LENGTH-1:0] remainder;
    logic                          div_by_zero;
    logic                          overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_divider.sv
// Sequential two's-complement divider: one restoring step per cycle on
// operand magnitudes, signs reapplied at the end. Quotient truncates toward
// zero and the remainder carries the dividend's sign. Divide-by-zero and the
// single overflowing case (most-negative / -1) bypass the iteration.
module signed_divider #(
    parameter int WORD_LENGTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    signed_divider_if.slave bus
);
    localparam int W     = WORD_LENGTH;
    localparam int CNT_W = $clog2(WORD_LENGTH);

    localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(WORD_LENGTH - 1);
    localparam logic [W-1:0]        ONE       = W'(1);
    localparam logic signed [W-1:0] MOST_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MINUS_ONE = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        FIX_SIGN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Unsigned magnitude; the most-negative value maps to 2^(W-1) exactly
    // because the result is read as unsigned.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] value);
        magnitude = value[W-1] ? (~value + ONE) : value;
    endfunction

    // Two's-complement negate when requested; zero stays zero.
    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
        apply_sign = neg ? (~mag + ONE) : mag;
    endfunction

    logic signed [W-1:0] op_dividend;
    logic signed [W-1:0] op_divisor;
    logic                q_sign;
    logic                r_sign;
    logic [W-1:0]        dvd_mag;
    logic [W-1:0]        dvs_mag;
    logic [W-1:0]        q_mag;
    logic [W:0]          part_rem;
    logic [CNT_W-1:0]    iter;
    logic                special_dbz;
    logic                special_ovf;

    logic signed [W-1:0] quotient_reg;
    logic signed [W-1:0] remainder_reg;
    logic                dbz_reg;
    logic                ovf_reg;

    logic                busy;
    logic                done;

    logic                div_zero_now;
    logic                overflow_now;
    logic [W+1:0]        trial;
    logic [W:0]          diff;
    logic                step_ok;

    assign div_zero_now = (op_divisor == '0);
    assign overflow_now = (op_dividend == MOST_NEG) && (op_divisor == MINUS_ONE);

    // One restoring step: shifted partial remainder with next dividend bit,
    // trial-subtracted by the divisor magnitude.
    always_comb begin
        trial   = {part_rem, dvd_mag[W-1]};
        step_ok = (trial >= {2'b00, dvs_mag});
        diff    = trial[W:0] - {1'b0, dvs_mag};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode. Special cases leave LOAD through the
    // one-cycle finalize slot so every result reaches DONE via the same
    // registered path, with a fixed two-edge latency.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (div_zero_now || overflow_now) begin
                    state_next = FIX_SIGN;
                end else begin
                    state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                if (iter == LAST_ITER) begin
                    state_next = FIX_SIGN;
                end
            end
            FIX_SIGN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, magnitude iteration and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_dividend   <= '0;
            op_divisor    <= '0;
            q_sign        <= 1'b0;
            r_sign        <= 1'b0;
            dvd_mag       <= '0;
            dvs_mag       <= '0;
            q_mag         <= '0;
            part_rem      <= '0;
            iter          <= '0;
            special_dbz   <= 1'b0;
            special_ovf   <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_dividend <= bus.dividend;
                        op_divisor  <= bus.divisor;
                    end
                end
                LOAD: begin
                    q_sign      <= op_dividend[W-1] ^ op_divisor[W-1];
                    r_sign      <= op_dividend[W-1];
                    dvd_mag     <= magnitude(op_dividend);
                    dvs_mag     <= magnitude(op_divisor);
                    q_mag       <= '0;
                    part_rem    <= '0;
                    iter        <= '0;
                    special_dbz <= div_zero_now;
                    special_ovf <= overflow_now && !div_zero_now;
                end
                DIVIDE: begin
                    part_rem <= step_ok ? diff : trial[W:0];
                    dvd_mag  <= {dvd_mag[W-2:0], 1'b0};
                    q_mag    <= {q_mag[W-2:0], step_ok};
                    iter     <= iter + CNT_W'(1);
                end
                FIX_SIGN: begin
                    if (special_dbz) begin
                        quotient_reg  <= '0;
                        remainder_reg <= op_dividend;
                        dbz_reg       <= 1'b1;
                        ovf_reg       <= 1'b0;
                    end else if (special_ovf) begin
                        quotient_reg  <= MOST_NEG;
                        remainder_reg <= '0;
                        dbz_reg       <= 1'b0;
                        ovf_reg       <= 1'b1;
                    end else begin
                        quotient_reg  <= apply_sign(q_mag, q_sign);
                        remainder_reg <= apply_sign(part_rem[W-1:0], r_sign);
                        dbz_reg       <= 1'b0;
                        ovf_reg       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overflow    = ovf_reg;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider at WORD_LENGTH=16: directed
// scenarios followed by random operands, compared against an integer
// arithmetic reference.
module tb_signed_divider;
    localparam int WL = 16;

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    signed_divider_if #(.WORD_LENGTH(WL)) bus ();

    signed_divider #(.WORD_LENGTH(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Reference: integer division truncates toward zero and the remainder
    // takes the dividend's sign; the two exception cases are fixed values.
    task automatic model(input logic signed [WL-1:0] a, input logic signed [WL-1:0] b,
                         output logic [WL-1:0] q, output logic [WL-1:0] r,
                         output logic dz, output logic ov, output int lat);
        longint la;
        longint lb;
        la = a;
        lb = b;
        dz = 1'b0;
        ov = 1'b0;
        if (lb == 0) begin
            q   = '0;
            r   = a;
            dz  = 1'b1;
            lat = 2;
        end else if (la == -(longint'(1) << (WL - 1)) && lb == -1) begin
            q   = {1'b1, {(WL-1){1'b0}}};
            r   = '0;
            ov  = 1'b1;
            lat = 2;
        end else begin
            q   = WL'(la / lb);
            r   = WL'(la % lb);
            lat = WL + 2;
        end
    endtask

    task automatic run_op(input logic signed [WL-1:0] a, input logic signed [WL-1:0] b,
                          input bit disturb);
        logic [WL-1:0] eq;
        logic [WL-1:0] er;
        logic          ez;
        logic          eo;
        int            lat;
        int            n;
        model(a, b, eq, er, ez, eo, lat);
        @(negedge clk);
        check("done_low_before_start", 32'(bus.done), 0);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = WL'($urandom);
        bus.divisor  = WL'($urandom);
        n = 0;
        check("busy_after_accept", 32'(bus.busy), 1);
        while (bus.done !== 1'b1 && n < 40) begin
            if (disturb && n == 6) begin
                bus.start    = 1'b1;
                bus.dividend = WL'($urandom);
                bus.divisor  = WL'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check($sformatf("latency %0d/%0d", a, b), 32'(n), 32'(lat));
        check($sformatf("quotient %0d/%0d", a, b), 32'($unsigned(bus.quotient)), 32'(eq));
        check($sformatf("remainder %0d/%0d", a, b), 32'($unsigned(bus.remainder)), 32'(er));
        check($sformatf("div_by_zero %0d/%0d", a, b), 32'(bus.div_by_zero), 32'(ez));
        check($sformatf("overflow %0d/%0d", a, b), 32'(bus.overflow), 32'(eo));
        check("busy_low_in_done", 32'(bus.busy), 0);
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        logic signed [WL-1:0] ra;
        logic signed [WL-1:0] rb;
        checks       = 0;
        passes       = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_quotient", 32'($unsigned(bus.quotient)), 0);
        check("rst_remainder", 32'($unsigned(bus.remainder)), 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        reset = 1'b1;

        // directed cases, issued back-to-back
        run_op(16'sd100, 16'sd7, 1'b0);
        check("const_q_100_7", 32'($unsigned(bus.quotient)), 32'd14);
        check("const_r_100_7", 32'($unsigned(bus.remainder)), 32'd2);
        run_op(-16'sd100, 16'sd7, 1'b0);
        check("const_q_m100_7", 32'($unsigned(bus.quotient)), 32'h0000_FFF2);
        check("const_r_m100_7", 32'($unsigned(bus.remainder)), 32'h0000_FFFE);
        run_op(16'sd100, -16'sd7, 1'b0);
        run_op(-16'sd100, -16'sd7, 1'b0);
        run_op(16'sd5, 16'sd0, 1'b0);
        run_op(16'sh8000, -16'sd1, 1'b0);
        check("const_q_ovf", 32'($unsigned(bus.quotient)), 32'h0000_8000);
        run_op(16'sh8000, 16'sd1, 1'b0);
        run_op(16'sd3, 16'sd7, 1'b0);
        run_op(-16'sd3, 16'sd7, 1'b0);
        run_op(16'sd0, -16'sd5, 1'b0);
        run_op(16'sh8000, 16'sh8000, 1'b0);
        run_op(16'sh7FFF, 16'sh8000, 1'b0);

        // start pulse and operand churn during the iteration
        run_op(16'sd1234, -16'sd37, 1'b1);
        expect_no_done("no_extra_done", 25);

        // reset during iteration aborts with no done
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'sd100;
        bus.divisor  = 16'sd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_quotient", 32'($unsigned(bus.quotient)), 0);
        check("abort_remainder", 32'($unsigned(bus.remainder)), 0);
        check("abort_dbz", 32'(bus.div_by_zero), 0);
        check("abort_ovf", 32'(bus.overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        expect_no_done("abort_no_done", 25);
        run_op(16'sd100, 16'sd7, 1'b0);

        // random operands with occasional exception cases
        for (int i = 0; i < 40; i++) begin
            ra = WL'($urandom);
            rb = WL'($urandom);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin
                    ra = 16'sh8000;
                    rb = -16'sd1;
                end
                2: begin
                    rb = WL'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: begin
                end
            endcase
            run_op(ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
